// File: rtl/irq_controller_pkg.sv
// -----------------------------------------------------------------------------
// irq_controller_pkg
//   Constants shared by the interrupt controller and the core it feeds:
//   register map, vector register layout and the two core vector addresses.
// -----------------------------------------------------------------------------
package irq_controller_pkg;

    // Width of a source index stored in VEC0/VEC1 (sources 0..7).
    localparam int IRQ_IDX_W = 3;

    // Register map on the 8-bit register port.
    typedef enum logic [2:0] {
        IRQ_REG_PEND = 3'd0,
        IRQ_REG_MASK = 3'd1,
        IRQ_REG_MODE = 3'd2,
        IRQ_REG_PRIO = 3'd3,
        IRQ_REG_VEC0 = 3'd4,
        IRQ_REG_VEC1 = 3'd5,
        IRQ_REG_RAW  = 3'd6,
        IRQ_REG_RSVD = 3'd7
    } irq_reg_e;

    // Bit of VEC0/VEC1 that flags a captured, not yet read, winner.
    localparam int IRQ_VEC_VALID_BIT = 7;

    // Core vector addresses for the two interrupt lines.
    localparam logic [15:0] IRQ_INT0_VECTOR = 16'h0004;
    localparam logic [15:0] IRQ_INT1_VECTOR = 16'h0008;

    // Builds a vector register value: valid flag plus source index.
    function automatic logic [7:0] irq_make_vec(input logic valid,
                                                input logic [IRQ_IDX_W-1:0] idx);
        logic [7:0] v;
        v = '0;
        v[IRQ_VEC_VALID_BIT] = valid;
        v[IRQ_IDX_W-1:0] = idx;
        return v;
    endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
//   Lowest-set-bit priority encoder.
//   req_i   : NSRC request vector
//   idx_o   : index of the lowest set bit (0 when none set)
//   valid_o : at least one bit of req_i is set
// -----------------------------------------------------------------------------
module irq_prio_enc
    import irq_controller_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0]      req_i,
    output logic [IRQ_IDX_W-1:0] idx_o,
    output logic                 valid_o
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IRQ_IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   Memory-mapped interrupt controller in front of the core. Synchronises up
//   to 8 external requests, qualifies them as edge or level, latches them in
//   PEND, masks them, and drives two registered request lines:
//   INT0 (vector 0x0004, high priority) and INT1 (vector 0x0008, low).
//   On ACK0/ACK1 the lowest-numbered qualifying source is captured in
//   VEC0/VEC1 for the handler to read.
//
// Ports
//   CLK, RESETN      : clock (rising edge), async active-low reset
//   IRQ[NSRC-1:0]    : raw asynchronous requests, active high
//   ACK0, ACK1       : one-cycle acknowledge pulses from the core
//   INT0, INT1       : registered requests to the core
//   ADDR, DIN, DOUT  : register select, write data, read data
//   WR, RD           : write strobe, read side-effect strobe
//
// Register port protocol: there is no handshake. WR high at a rising CLK
// writes DIN to ADDR that cycle. DOUT is combinational from ADDR and always
// valid; RD only marks a read that has side effects (clearing the valid bit
// of VEC0/VEC1). An ACK in the same cycle as such a read takes precedence.
// -----------------------------------------------------------------------------
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int NSRC        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic [NSRC-1:0] IRQ,
    input  logic            ACK0,
    input  logic            ACK1,
    output logic            INT0,
    output logic            INT1,
    input  logic [2:0]      ADDR,
    input  logic [7:0]      DIN,
    output logic [7:0]      DOUT,
    input  logic            WR,
    input  logic            RD
);

    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] sync_s;
    logic [NSRC-1:0] s_prev_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] prio_q, prio_d;
    logic [7:0]      vec0_q, vec0_d;
    logic [7:0]      vec1_q, vec1_d;
    logic            int0_q, int0_d;
    logic            int1_q, int1_d;

    logic [NSRC-1:0]      req0, req1;
    logic [IRQ_IDX_W-1:0] idx0, idx1;
    logic                 vld0, vld1;
    logic [NSRC-1:0]      w1c;
    logic [NSRC-1:0]      ack_clr;
    logic [NSRC-1:0]      rise;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~s_prev_q;

    // Winners are taken from the registered state the core saw.
    assign req0 = pend_q & mask_q & prio_q;
    assign req1 = pend_q & mask_q & ~prio_q;

    irq_prio_enc #(.NSRC(NSRC)) u_enc0 (
        .req_i   (req0),
        .idx_o   (idx0),
        .valid_o (vld0)
    );

    irq_prio_enc #(.NSRC(NSRC)) u_enc1 (
        .req_i   (req1),
        .idx_o   (idx1),
        .valid_o (vld1)
    );

    always_comb begin : next_state
        mask_d = mask_q;
        mode_d = mode_q;
        prio_d = prio_q;
        w1c    = '0;
        if (WR) begin
            case (irq_reg_e'(ADDR))
                IRQ_REG_PEND: w1c    = DIN[NSRC-1:0] & ~mode_q;
                IRQ_REG_MASK: mask_d = DIN[NSRC-1:0];
                IRQ_REG_MODE: mode_d = DIN[NSRC-1:0];
                IRQ_REG_PRIO: prio_d = DIN[NSRC-1:0];
                default:      ;
            endcase
        end

        ack_clr = '0;
        if (ACK0 && vld0) ack_clr[idx0] = 1'b1;
        if (ACK1 && vld1) ack_clr[idx1] = 1'b1;

        // Level bits mirror the synchronised input. Edge bits hold until
        // cleared; a new edge is OR'd in last so it beats W1C and ACK clears.
        pend_d = (mode_q & sync_s)
               | (~mode_q & (rise | (pend_q & ~w1c & ~ack_clr)));

        vec0_d = vec0_q;
        if (RD && (irq_reg_e'(ADDR) == IRQ_REG_VEC0)) vec0_d[IRQ_VEC_VALID_BIT] = 1'b0;
        if (ACK0) begin
            if (vld0) vec0_d = irq_make_vec(1'b1, idx0);
            else      vec0_d[IRQ_VEC_VALID_BIT] = 1'b0;
        end

        vec1_d = vec1_q;
        if (RD && (irq_reg_e'(ADDR) == IRQ_REG_VEC1)) vec1_d[IRQ_VEC_VALID_BIT] = 1'b0;
        if (ACK1) begin
            if (vld1) vec1_d = irq_make_vec(1'b1, idx1);
            else      vec1_d[IRQ_VEC_VALID_BIT] = 1'b0;
        end

        // Built from next-state values so INT reflects PEND/MASK/PRIO from the
        // same edge that updates them (3-edge request latency, 1-edge unmask).
        int0_d = |(pend_d & mask_d & prio_d);
        int1_d = |(pend_d & mask_d & ~prio_d);
    end

    always_ff @(posedge CLK or negedge RESETN) begin : sync_regs
        if (!RESETN) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_prev_q <= '0;
        end else begin
            sync_q[0] <= IRQ;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_prev_q <= sync_s;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin : state_regs
        if (!RESETN) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            prio_q <= '0;
            vec0_q <= '0;
            vec1_q <= '0;
            int0_q <= 1'b0;
            int1_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            prio_q <= prio_d;
            vec0_q <= vec0_d;
            vec1_q <= vec1_d;
            int0_q <= int0_d;
            int1_q <= int1_d;
        end
    end

    assign INT0 = int0_q;
    assign INT1 = int1_q;

    always_comb begin : read_mux
        DOUT = 8'h00;
        case (irq_reg_e'(ADDR))
            IRQ_REG_PEND: DOUT = 8'(pend_q);
            IRQ_REG_MASK: DOUT = 8'(mask_q);
            IRQ_REG_MODE: DOUT = 8'(mode_q);
            IRQ_REG_PRIO: DOUT = 8'(prio_q);
            IRQ_REG_VEC0: DOUT = vec0_q;
            IRQ_REG_VEC1: DOUT = vec1_q;
            IRQ_REG_RAW:  DOUT = 8'(sync_s);
            default:      DOUT = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//   Directed scenarios against hand-derived constants plus a randomized run
//   checked against a behavioural reference model of the controller.
// -----------------------------------------------------------------------------
module tb_irq_controller;

    localparam int NSRC        = 8;
    localparam int SYNC_STAGES = 2;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [7:0] IRQ;
    logic       ACK0, ACK1;
    logic       INT0, INT1;
    logic [2:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       WR, RD;

    int tests_run  = 0;
    int fail_count = 0;
    logic [7:0] exp_q[$];

    irq_controller #(.NSRC(NSRC), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .IRQ    (IRQ),
        .ACK0   (ACK0),
        .ACK1   (ACK1),
        .INT0   (INT0),
        .INT1   (INT1),
        .ADDR   (ADDR),
        .DIN    (DIN),
        .DOUT   (DOUT),
        .WR     (WR),
        .RD     (RD)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Request inputs reach the edge/level logic through a SYNC_STAGES-deep
    // delay line; everything else follows the register-map rules directly.
    logic [7:0] m_hist [SYNC_STAGES];
    logic [7:0] m_prev, m_pend, m_mask, m_mode, m_prio, m_vec0, m_vec1;
    logic       m_int0, m_int1;

    function automatic int lowest(input logic [7:0] q);
        for (int i = 0; i < 8; i++) if (q[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_next_reg(input logic [2:0] a, input logic [7:0] cur);
        return (WR && ADDR == a) ? DIN : cur;
    endfunction

    function automatic logic [7:0] m_next_vec(input logic [7:0] cur, input logic ack,
                                              input logic [7:0] q, input logic rdclr);
        logic [7:0] v;
        int w;
        v = cur;
        if (rdclr) v[7] = 1'b0;
        if (ack) begin
            w = lowest(q);
            if (w >= 0) v = 8'h80 | 8'(w);
            else        v[7] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [7:0] m_next_pend();
        logic [7:0] s, clr, nx;
        int w0, w1;
        s   = m_hist[SYNC_STAGES-1];
        clr = 8'h00;
        w0  = lowest(m_pend & m_mask & m_prio);
        w1  = lowest(m_pend & m_mask & ~m_prio);
        if (ACK0 && w0 >= 0) clr[w0] = 1'b1;
        if (ACK1 && w1 >= 0) clr[w1] = 1'b1;
        if (WR && ADDR == 3'd0) clr = clr | DIN;
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i])                nx[i] = s[i];
            else if (s[i] && !m_prev[i])  nx[i] = 1'b1;
            else                          nx[i] = m_pend[i] && !clr[i];
        end
        return nx;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_pend;
            3'd1: return m_mask;
            3'd2: return m_mode;
            3'd3: return m_prio;
            3'd4: return m_vec0;
            3'd5: return m_vec1;
            3'd6: return m_hist[SYNC_STAGES-1];
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge CLK or negedge RESETN) begin : ref_model
        if (!RESETN) begin
            for (int k = 0; k < SYNC_STAGES; k++) m_hist[k] <= 8'h00;
            m_prev <= 8'h00; m_pend <= 8'h00; m_mask <= 8'h00;
            m_mode <= 8'h00; m_prio <= 8'h00; m_vec0 <= 8'h00;
            m_vec1 <= 8'h00; m_int0 <= 1'b0;  m_int1 <= 1'b0;
        end else begin
            m_pend <= m_next_pend();
            m_mask <= m_next_reg(3'd1, m_mask);
            m_mode <= m_next_reg(3'd2, m_mode);
            m_prio <= m_next_reg(3'd3, m_prio);
            m_vec0 <= m_next_vec(m_vec0, ACK0, m_pend & m_mask & m_prio,  RD && ADDR == 3'd4);
            m_vec1 <= m_next_vec(m_vec1, ACK1, m_pend & m_mask & ~m_prio, RD && ADDR == 3'd5);
            m_int0 <= |(m_next_pend() & m_next_reg(3'd1, m_mask) & m_next_reg(3'd3, m_prio));
            m_int1 <= |(m_next_pend() & m_next_reg(3'd1, m_mask) & ~m_next_reg(3'd3, m_prio));
            m_hist[0] <= IRQ;
            for (int k = 1; k < SYNC_STAGES; k++) m_hist[k] <= m_hist[k-1];
            m_prev <= m_hist[SYNC_STAGES-1];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        RESETN = 1'b0; IRQ = 8'h00; ACK0 = 1'b0; ACK1 = 1'b0;
        WR = 1'b0; RD = 1'b0; ADDR = 3'd0; DIN = 8'h00;
        repeat (3) @(negedge CLK);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        ADDR = a; DIN = d; WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        ADDR = a;
        #1;
        v = DOUT;
    endtask

    task automatic rd_clear(input logic [2:0] a);
        ADDR = a; RD = 1'b1;
        @(negedge CLK);
        RD = 1'b0;
    endtask

    task automatic pulse_ack(input logic a0, input logic a1);
        ACK0 = a0; ACK1 = a1;
        @(negedge CLK);
        ACK0 = 1'b0; ACK1 = 1'b0;
    endtask

    // One-cycle pulse on IRQ, then wait until PEND has latched it.
    task automatic pulse_irq_and_latch(input logic [7:0] bits);
        IRQ = bits;
        @(negedge CLK);
        IRQ = 8'h00;
        repeat (2) @(negedge CLK);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] v, e;
        RESETN = 1'b0; ACK0 = 1'b0; ACK1 = 1'b0; WR = 1'b0; RD = 1'b0;
        ADDR = 3'd0; DIN = 8'h00; IRQ = 8'h00;
        repeat (2) @(negedge CLK);
        IRQ = 8'hFF; @(negedge CLK);
        IRQ = 8'h00; @(negedge CLK);
        IRQ = 8'hFF; @(negedge CLK);
        tests_run++;
        if ({INT0, INT1} !== 2'b00) begin
            fail_count++;
            $display("FAIL reset_int: got %b required 00", {INT0, INT1});
        end
        for (int a = 0; a < 8; a++) exp_q.push_back(8'h00);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            e = exp_q.pop_front();
            tests_run++;
            if (v !== e) begin
                fail_count++;
                $display("FAIL reset_reg%0d: got %h required %h", a, v, e);
            end
        end
        RESETN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            IRQ = ~IRQ;
            tests_run++;
            if ({INT0, INT1} !== 2'b00) begin
                fail_count++;
                $display("FAIL reset_masked_c%0d: got %b required 00", c, {INT0, INT1});
            end
        end
    endtask

    task automatic test_edge_int1();
        logic [7:0] v;
        do_reset();
        wr(3'd1, 8'h01); wr(3'd2, 8'h00); wr(3'd3, 8'h00);
        IRQ = 8'h01;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            IRQ = 8'h00;
            tests_run++;
            if (INT1 !== (k == 3)) begin
                fail_count++;
                $display("FAIL edge_latency_edge%0d: INT1 got %b required %b", k, INT1, (k == 3));
            end
        end
        rd(3'd0, v);
        tests_run++;
        if (v !== 8'h01) begin fail_count++; $display("FAIL edge_pend: got %h required 01", v); end
        pulse_ack(1'b0, 1'b1);
        tests_run++;
        if ({INT0, INT1} !== 2'b00) begin fail_count++; $display("FAIL edge_ack_int: got %b required 00", {INT0, INT1}); end
        rd(3'd5, v);
        tests_run++;
        if (v !== 8'h80) begin fail_count++; $display("FAIL edge_vec1: got %h required 80", v); end
        rd(3'd0, v);
        tests_run++;
        if (v !== 8'h00) begin fail_count++; $display("FAIL edge_pend_cleared: got %h required 00", v); end
        rd_clear(3'd5);
        rd(3'd5, v);
        tests_run++;
        if (v !== 8'h00) begin fail_count++; $display("FAIL edge_vec1_rdclr: got %h required 00", v); end
    endtask

    task automatic test_priority();
        logic [7:0] v;
        do_reset();
        wr(3'd1, 8'hFF); wr(3'd3, 8'h0C);
        IRQ = 8'h0C;
        repeat (3) @(negedge CLK);
        tests_run++;
        if ({INT0, INT1} !== 2'b10) begin fail_count++; $display("FAIL prio_int: got %b required 10", {INT0, INT1}); end
        pulse_ack(1'b1, 1'b0);
        rd(3'd4, v);
        tests_run++;
        if (v !== 8'h82) begin fail_count++; $display("FAIL prio_vec0_first: got %h required 82", v); end
        tests_run++;
        if (INT0 !== 1'b1) begin fail_count++; $display("FAIL prio_int0_held: got %b required 1", INT0); end
        pulse_ack(1'b1, 1'b0);
        rd(3'd4, v);
        tests_run++;
        if (v !== 8'h83) begin fail_count++; $display("FAIL prio_vec0_second: got %h required 83", v); end
        tests_run++;
        if (INT0 !== 1'b0) begin fail_count++; $display("FAIL prio_int0_low: got %b required 0", INT0); end
        IRQ = 8'h00;
    endtask

    task automatic test_level();
        logic [7:0] v;
        do_reset();
        wr(3'd2, 8'h10); wr(3'd1, 8'h10); wr(3'd3, 8'h00);
        IRQ = 8'h10;
        repeat (3) @(negedge CLK);
        tests_run++;
        if (INT1 !== 1'b1) begin fail_count++; $display("FAIL level_int1: got %b required 1", INT1); end
        pulse_ack(1'b0, 1'b1);
        tests_run++;
        if (INT1 !== 1'b1) begin fail_count++; $display("FAIL level_after_ack: got %b required 1", INT1); end
        rd(3'd5, v);
        tests_run++;
        if (v !== 8'h84) begin fail_count++; $display("FAIL level_vec1: got %h required 84", v); end
        wr(3'd0, 8'h10);
        rd(3'd0, v);
        tests_run++;
        if (v !== 8'h10 || INT1 !== 1'b1) begin
            fail_count++;
            $display("FAIL level_after_w1c: pend %h int1 %b required 10/1", v, INT1);
        end
        IRQ = 8'h00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            tests_run++;
            if (INT1 !== (k < 3)) begin
                fail_count++;
                $display("FAIL level_drop_edge%0d: INT1 got %b required %b", k, INT1, (k < 3));
            end
        end
    endtask

    task automatic test_mask();
        logic [7:0] v;
        do_reset();
        pulse_irq_and_latch(8'h02);
        @(negedge CLK);
        rd(3'd0, v);
        tests_run++;
        if (v !== 8'h02 || INT1 !== 1'b0) begin
            fail_count++;
            $display("FAIL mask_latch: pend %h int1 %b required 02/0", v, INT1);
        end
        wr(3'd1, 8'h02);
        tests_run++;
        if (INT1 !== 1'b1) begin fail_count++; $display("FAIL mask_unmask_int1: got %b required 1", INT1); end
        wr(3'd1, 8'h00);
        rd(3'd0, v);
        tests_run++;
        if (INT1 !== 1'b0 || v !== 8'h02) begin
            fail_count++;
            $display("FAIL mask_remask: int1 %b pend %h required 0/02", INT1, v);
        end
    endtask

    task automatic test_races();
        logic [7:0] v;
        // W1C on the same edge a new synchronised edge arrives: set wins.
        do_reset();
        wr(3'd1, 8'h01);
        pulse_irq_and_latch(8'h01);
        IRQ = 8'h01;                 // second pulse; PEND sets 3 edges later
        @(negedge CLK);
        IRQ = 8'h00;
        @(negedge CLK);
        wr(3'd0, 8'h01);             // sampled on that same third edge
        rd(3'd0, v);
        tests_run++;
        if (v !== 8'h01) begin fail_count++; $display("FAIL race_w1c_set_wins: got %h required 01", v); end
        wr(3'd0, 8'h01);
        rd(3'd0, v);
        tests_run++;
        if (v !== 8'h00) begin fail_count++; $display("FAIL race_w1c_plain: got %h required 00", v); end

        // ACK clear on the same edge as a new edge: set wins.
        pulse_irq_and_latch(8'h01);
        IRQ = 8'h01;
        @(negedge CLK);
        IRQ = 8'h00;
        @(negedge CLK);
        pulse_ack(1'b0, 1'b1);
        rd(3'd0, v);
        tests_run++;
        if (v !== 8'h01 || INT1 !== 1'b1) begin
            fail_count++;
            $display("FAIL race_ack_set_wins: pend %h int1 %b required 01/1", v, INT1);
        end
        rd(3'd5, v);
        tests_run++;
        if (v !== 8'h80) begin fail_count++; $display("FAIL race_ack_vec1: got %h required 80", v); end

        // ACK with nothing qualifying: valid drops, index is kept.
        do_reset();
        wr(3'd1, 8'h04);
        pulse_irq_and_latch(8'h04);
        pulse_ack(1'b0, 1'b1);
        rd(3'd5, v);
        tests_run++;
        if (v !== 8'h82) begin fail_count++; $display("FAIL empty_ack_first: got %h required 82", v); end
        pulse_ack(1'b0, 1'b1);
        rd(3'd5, v);
        tests_run++;
        if (v !== 8'h02) begin fail_count++; $display("FAIL empty_ack_vec1: got %h required 02", v); end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] v, e;
        do_reset();
        wr(3'd1, 8'h01); wr(3'd3, 8'h01);
        pulse_irq_and_latch(8'h01);
        tests_run++;
        if (INT0 !== 1'b1) begin fail_count++; $display("FAIL midrst_pre_int0: got %b required 1", INT0); end
        #2 RESETN = 1'b0;
        #1;
        tests_run++;
        if (INT0 !== 1'b0) begin fail_count++; $display("FAIL midrst_async_int0: got %b required 0", INT0); end
        #9 RESETN = 1'b1;
        for (int a = 0; a < 8; a++) exp_q.push_back(8'h00);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            e = exp_q.pop_front();
            tests_run++;
            if (v !== e) begin fail_count++; $display("FAIL midrst_reg%0d: got %h required %h", a, v, e); end
        end
        repeat (3) @(negedge CLK);
        tests_run++;
        if ({INT0, INT1} !== 2'b00) begin fail_count++; $display("FAIL midrst_no_glitch: got %b required 00", {INT0, INT1}); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            tests_run++;
            if (INT0 !== m_int0) begin fail_count++; $display("FAIL rand_int0 c%0d: got %b required %b", c, INT0, m_int0); end
            tests_run++;
            if (INT1 !== m_int1) begin fail_count++; $display("FAIL rand_int1 c%0d: got %b required %b", c, INT1, m_int1); end
            tests_run++;
            if (DOUT !== m_read(ADDR)) begin
                fail_count++;
                $display("FAIL rand_dout c%0d addr %0d: got %h required %h", c, ADDR, DOUT, m_read(ADDR));
            end
            if ($urandom_range(0, 2) == 0) IRQ = IRQ ^ 8'($urandom);
            ACK0 = ($urandom_range(0, 5) == 0);
            ACK1 = ($urandom_range(0, 5) == 0);
            WR   = ($urandom_range(0, 3) == 0);
            RD   = ($urandom_range(0, 1) == 0);
            ADDR = 3'($urandom_range(0, 7));
            DIN  = 8'($urandom);
        end
        ACK0 = 1'b0; ACK1 = 1'b0; WR = 1'b0; RD = 1'b0; IRQ = 8'h00;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_edge_int1();
        test_priority();
        test_level();
        test_mask();
        test_races();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
